// File: rtl/dsm_pkg.sv
// Shared constants for the delta-sigma modulator and its CIC decimator.
// Holds the filter order and the accumulator width rule used by dsm_cic_decimator.
package dsm_pkg;

    localparam int CIC_ORDER = 3;

    // Modulator side: multi-level output sample width and oversampling ratio.
    localparam int DSM_OUT_W = 4;
    localparam int DSM_OSR   = 16;

    // Accumulator width that holds the full sinc^N DC gain without ambiguity.
    function automatic int cic_acc_w(input int in_w, input int dec_r);
        return in_w + CIC_ORDER * $clog2(dec_r);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb section of the CIC decimator: y = x - x_prev, evaluated on each valid input.
// Runs at the decimated rate; valid propagates one clock per stage.
module cic_comb_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_v,
    input  logic [W-1:0] in_d,
    output logic         out_v,
    output logic [W-1:0] out_d
);

    logic [W-1:0] z_reg;
    logic [W-1:0] out_d_reg;
    logic         out_v_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_reg     <= '0;
            out_d_reg <= '0;
            out_v_reg <= 1'b0;
        end else begin
            out_v_reg <= in_v;
            if (in_v) begin
                out_d_reg <= in_d - z_reg;
                z_reg     <= in_d;
            end
        end
    end

    assign out_v = out_v_reg;
    assign out_d = out_d_reg;

endmodule

// File: rtl/dsm_cic_decimator.sv
// Third-order CIC (sinc^3) decimator reconstructing words from a multi-level DSM stream.
// Optional macro DSM_CIC_ROUND_EN selects round-half-up with positive clamp instead of truncation.
module dsm_cic_decimator
    import dsm_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int DEC_R = 16,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data
);

    localparam int ACC_W = cic_acc_w(IN_W, DEC_R);
    localparam int CNT_W = (DEC_R > 1) ? $clog2(DEC_R) : 1;
    localparam int SHIFT = ACC_W - OUT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC_R - 1);

    genvar gi;

    logic [ACC_W-1:0] in_ext;
    assign in_ext = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};

    // Integrator chain; each stage adds the previous stage's old value, so it is pipelined.
    logic [CIC_ORDER-1:0][ACC_W-1:0] integ_q;

    for (gi = 0; gi < CIC_ORDER; gi++) begin : g_integ
        logic [ACC_W-1:0] acc_reg;
        logic [ACC_W-1:0] addend;

        if (gi == 0) begin : g_first
            assign addend = in_ext;
        end else begin : g_rest
            assign addend = integ_q[gi-1];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_reg <= '0;
            end else if (in_valid) begin
                acc_reg <= acc_reg + addend;
            end
        end

        assign integ_q[gi] = acc_reg;
    end

    logic [CNT_W-1:0] cnt_reg;
    logic             tick;

    assign tick = in_valid && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (in_valid) begin
            cnt_reg <= tick ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    // Decimation sample: captures the last integrator before this cycle's update.
    logic [ACC_W-1:0] c0_reg;
    logic             v0_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c0_reg <= '0;
            v0_reg <= 1'b0;
        end else begin
            v0_reg <= tick;
            if (tick) begin
                c0_reg <= integ_q[CIC_ORDER-1];
            end
        end
    end

    logic             comb_v [CIC_ORDER+1];
    logic [ACC_W-1:0] comb_d [CIC_ORDER+1];

    assign comb_v[0] = v0_reg;
    assign comb_d[0] = c0_reg;

    for (gi = 0; gi < CIC_ORDER; gi++) begin : g_comb
        cic_comb_stage #(
            .W(ACC_W)
        ) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .in_v (comb_v[gi]),
            .in_d (comb_d[gi]),
            .out_v(comb_v[gi+1]),
            .out_d(comb_d[gi+1])
        );
    end

    logic [ACC_W-1:0] y3;
    logic [OUT_W-1:0] scaled;

    assign y3 = comb_d[CIC_ORDER];

    if (SHIFT == 0) begin : g_scale_ident
        assign scaled = y3;
    end else begin : g_scale
`ifdef DSM_CIC_ROUND_EN
        localparam logic signed [ACC_W:0] HALF    = (ACC_W + 1)'(2 ** (SHIFT - 1));
        localparam logic signed [OUT_W:0] MAX_POS = (OUT_W + 1)'(2 ** (OUT_W - 1) - 1);

        logic signed [ACC_W:0] rounded;
        logic signed [OUT_W:0] shifted;

        // One guard bit keeps the rounding add from wrapping; only positive overflow is possible.
        assign rounded = $signed({y3[ACC_W-1], y3}) + HALF;
        assign shifted = (OUT_W + 1)'(rounded >>> SHIFT);
        assign scaled  = (shifted > MAX_POS) ? MAX_POS[OUT_W-1:0] : shifted[OUT_W-1:0];
`else
        assign scaled = OUT_W'($signed(y3) >>> SHIFT);
`endif
    end

    logic             out_valid_reg;
    logic [OUT_W-1:0] out_data_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= comb_v[CIC_ORDER];
            if (comb_v[CIC_ORDER]) begin
                out_data_reg <= scaled;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Scoreboard bench for dsm_cic_decimator: a default instance (DEC_R=16) and a DEC_R=2 instance.
// Stimulus pushes expected pulses (value, arrival cycle); one monitor pops and compares.
`timescale 1ns/1ps
module tb_dsm_cic_decimator;

    localparam int IN_W = 4;
    localparam int R1   = 16;
    localparam int OW1  = 12;
    localparam int R2   = 2;
    localparam int OW2  = 4;

`ifdef DSM_CIC_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst1_n, rst2_n;
    logic            v1, v2;
    logic [IN_W-1:0] d1, d2;
    logic            ov1, ov2;
    logic [OW1-1:0]  od1;
    logic [OW2-1:0]  od2;

    dsm_cic_decimator #(.IN_W(IN_W), .DEC_R(R1), .OUT_W(OW1)) u_dut (
        .clk(clk), .rst_n(rst1_n), .in_valid(v1), .in_data(d1),
        .out_valid(ov1), .out_data(od1)
    );

    dsm_cic_decimator #(.IN_W(IN_W), .DEC_R(R2), .OUT_W(OW2)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .in_valid(v2), .in_data(d2),
        .out_valid(ov2), .out_data(od2)
    );

    typedef struct {
        bit care;
        int val;
        int cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rq1 = 1'b1;
    logic rq2 = 1'b1;
    always @(posedge clk) begin
        rq1 <= rst1_n;
        rq2 <= rst2_n;
    end

    int fc1 = 0, fc2 = 0, pn1 = 0, pn2 = 0;
    bit end_req = 1'b0;

    // ---------------- stimulus ----------------
    task automatic drv1(input bit v, input int x, input int ex);
        v1 = v;
        d1 = IN_W'(x);
        if (v) begin
            if (fc1 == R1 - 1) begin
                q1.push_back(exp_t'{pn1 >= 4, ex, cyc + 5});
                fc1 = 0;
                pn1++;
            end else begin
                fc1++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drv2(input bit v, input int x, input int ex);
        v2 = v;
        d2 = IN_W'(x);
        if (v) begin
            if (fc2 == R2 - 1) begin
                q2.push_back(exp_t'{pn2 >= 4, ex, cyc + 5});
                fc2 = 0;
                pn2++;
            end else begin
                fc2++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic reset1();
        v1 = 1'b0; d1 = '0; rst1_n = 1'b0;
        @(posedge clk); #1;
        rst1_n = 1'b1; fc1 = 0; pn1 = 0;
    endtask

    task automatic reset2();
        v2 = 1'b0; d2 = '0; rst2_n = 1'b0;
        @(posedge clk); #1;
        rst2_n = 1'b1; fc2 = 0; pn2 = 0;
    endtask

    // DEC_R=2 periodic pairs (a,b): y3 = 4*(a+b), scaled by >>3 (truncate) or round-half-up.
    int pat_a[6] = '{ 1, 3, 1, 7, -1, -8};
    int pat_b[6] = '{-1, 3, 0, 6,  0, -8};
    int exp_t0[6] = '{0, 3, 0, 6, -1, -8};
    int exp_r0[6] = '{0, 3, 1, 7,  0, -8};

    initial begin
        rst1_n = 1'b0; rst2_n = 1'b0;
        v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0;
        @(posedge clk); #1;
        rst1_n = 1'b1; rst2_n = 1'b1;

        // DC x=3, continuous: 3*4096 >> 4 = 768
        reset1();
        repeat (10 * R1) drv1(1'b1, 3, 768);

        // 1-of-3 duty, junk on in_data during gaps: pulses every 48 clocks, same value
        repeat (8 * R1) begin
            drv1(1'b1, 3, 768);
            drv1(1'b0, 7, 768);
            drv1(1'b0, -5, 768);
        end

        // reset mid-frame after 7 samples; partial frame discarded
        repeat (7) drv1(1'b1, 3, 768);
        reset1();
        repeat (8 * R1) drv1(1'b1, 3, 768);
        repeat (10) drv1(1'b0, 0, 0);

        // DC x=-8 long run: integrators wrap many times, steady -32768 >> 4 = -2048
        reset1();
        repeat (10000) drv1(1'b1, -8, -2048);
        repeat (10) drv1(1'b0, 0, 0);

        // DEC_R=2 back-to-back ticks with periodic pairs, including rounding cases
        for (int p = 0; p < 6; p++) begin
            reset2();
            repeat (12) begin
                drv2(1'b1, pat_a[p], RND ? exp_r0[p] : exp_t0[p]);
                drv2(1'b1, pat_b[p], RND ? exp_r0[p] : exp_t0[p]);
            end
            repeat (8) drv2(1'b0, 0, 0);
        end

        end_req = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    exp_t e1, e2;
    int   last1 = 0, last2 = 0;
    bit   care1 = 1'b0, care2 = 1'b0;

    always @(negedge clk) begin
        // DUT1
        if (!rq1) begin
            chk("dut1_reset_valid", int'(ov1), 0);
            chk("dut1_reset_data", int'($signed(od1)), 0);
            last1 = 0; care1 = 1'b1;
        end else begin
            if (q1.size() > 0 && q1[0].cyc < cyc) begin
                chk("dut1_pulse_missing", cyc, q1[0].cyc);
                void'(q1.pop_front());
            end
            if (ov1) begin
                chk("dut1_pulse_pending", int'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    chk("dut1_pulse_cycle", cyc, e1.cyc);
                    if (e1.care) chk("dut1_data", int'($signed(od1)), e1.val);
                    $display("dut1 pulse cyc=%0d data=%0d expect=%0d checked=%0d",
                             cyc, $signed(od1), e1.val, e1.care);
                    last1 = e1.val; care1 = e1.care;
                end
            end else if (care1) begin
                chk("dut1_hold", int'($signed(od1)), last1);
            end
        end

        // DUT2
        if (!rq2) begin
            chk("dut2_reset_valid", int'(ov2), 0);
            chk("dut2_reset_data", int'($signed(od2)), 0);
            last2 = 0; care2 = 1'b1;
        end else begin
            if (q2.size() > 0 && q2[0].cyc < cyc) begin
                chk("dut2_pulse_missing", cyc, q2[0].cyc);
                void'(q2.pop_front());
            end
            if (ov2) begin
                chk("dut2_pulse_pending", int'(q2.size() > 0), 1);
                if (q2.size() > 0) begin
                    e2 = q2.pop_front();
                    chk("dut2_pulse_cycle", cyc, e2.cyc);
                    if (e2.care) chk("dut2_data", int'($signed(od2)), e2.val);
                    $display("dut2 pulse cyc=%0d data=%0d expect=%0d checked=%0d",
                             cyc, $signed(od2), e2.val, e2.care);
                    last2 = e2.val; care2 = e2.care;
                end
            end else if (care2) begin
                chk("dut2_hold", int'($signed(od2)), last2);
            end
        end

        if (end_req) begin
            chk("dut1_queue_drained", q1.size(), 0);
            chk("dut2_queue_drained", q2.size(), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
